// File: rtl/bsg_parallel_in_serial_out_passthrough_pkg.sv
// Shared constants and helpers for the parallel-in/serial-out passthrough.
// Sizes the beat counter and the length field for any els_p >= 1.
package bsg_parallel_in_serial_out_passthrough_pkg;

    // A one-word packet still needs a 1-bit length/index field.
    function automatic int safe_clog2(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bsg_parallel_in_serial_out_passthrough_if.sv
// Parallel (wide) and serial (narrow) valid/ready-and channels of the converter.
// The parallel side carries the packet and its length; the serial side carries one word per beat.
interface bsg_parallel_in_serial_out_passthrough_if
    import bsg_parallel_in_serial_out_passthrough_pkg::*;
#(
    parameter int width_p = 8,
    parameter int els_p   = 4
);
    localparam int lg_els_lp = safe_clog2(els_p);

    logic                             par_v;
    logic                             par_ready_and;
    logic [els_p-1:0][width_p-1:0]    par_data;
    logic [lg_els_lp-1:0]             par_len;

    logic                             ser_v;
    logic                             ser_ready_and;
    logic [width_p-1:0]               ser_data;
    logic                             ser_last;

    modport par_master (output par_v, par_data, par_len, input  par_ready_and);
    modport par_slave  (input  par_v, par_data, par_len, output par_ready_and);
    modport ser_master (output ser_v, ser_data, ser_last, input  ser_ready_and);
    modport ser_slave  (input  ser_v, ser_data, ser_last, output ser_ready_and);

endinterface

// File: rtl/bsg_array_reverse.sv
// Reverses the element order of a packed array: o[k] = i[els_p-1-k].
module bsg_array_reverse #(
    parameter int width_p = 8,
    parameter int els_p   = 4
) (
    input  logic [els_p-1:0][width_p-1:0] i,
    output logic [els_p-1:0][width_p-1:0] o
);

    for (genvar k = 0; k < els_p; k++) begin : g_rev
        assign o[k] = i[els_p-1-k];
    end

endmodule

// File: rtl/bsg_piso_beat_counter.sv
// Beat counter for the serializer: index of the next word to send.
// Clear wins over increment so the final beat always returns the index to word 0.
module bsg_piso_beat_counter #(
    parameter int width_p = 2
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               clear_i,
    input  logic               up_i,
    output logic [width_p-1:0] count_o
);

    logic [width_p-1:0] count_r;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            count_r <= '0;
        end else if (clear_i) begin
            count_r <= '0;
        end else if (up_i) begin
            count_r <= count_r + width_p'(1);
        end
    end

    assign count_o = count_r;

endmodule

// File: rtl/bsg_parallel_in_serial_out_passthrough.sv
// Parallel-in, serial-out converter without data buffering: the serial word is muxed
// straight from the upstream-held packet, and the only state is the beat index.
module bsg_parallel_in_serial_out_passthrough
    import bsg_parallel_in_serial_out_passthrough_pkg::*;
#(
    parameter int width_p    = 8,
    parameter int els_p      = 4,
    parameter int hi_to_lo_p = 0,
    parameter int use_len_p  = 0
) (
    input  logic                                     clk_i,
    input  logic                                     reset_n_i,
    bsg_parallel_in_serial_out_passthrough_if.par_slave  par,
    bsg_parallel_in_serial_out_passthrough_if.ser_master ser
);

    localparam int                   lg_els_lp  = safe_clog2(els_p);
    localparam logic [lg_els_lp-1:0] max_idx_lp = lg_els_lp'(els_p - 1);

    logic [els_p-1:0][width_p-1:0] words;
    logic [lg_els_lp-1:0]          count_r;
    logic [lg_els_lp-1:0]          len_eff;
    logic                          last;
    logic                          send;

    // Reversal happens ahead of the index mux so the counter always runs 0..len_eff.
    if (hi_to_lo_p != 0) begin : g_hi_to_lo
        bsg_array_reverse #(
            .width_p (width_p),
            .els_p   (els_p)
        ) reverse (
            .i (par.par_data),
            .o (words)
        );
    end else begin : g_lo_to_hi
        assign words = par.par_data;
    end

    if (use_len_p != 0) begin : g_len
        assign len_eff = (par.par_len > max_idx_lp) ? max_idx_lp : par.par_len;
    end else begin : g_no_len
        logic unused_len;
        assign len_eff    = max_idx_lp;
        assign unused_len = ^par.par_len;
    end

    assign last = (count_r == len_eff);
    assign send = par.par_v & ser.ser_ready_and;

    if (els_p > 1) begin : g_count
        bsg_piso_beat_counter #(
            .width_p (lg_els_lp)
        ) beat_counter (
            .clk_i     (clk_i),
            .reset_n_i (reset_n_i),
            .clear_i   (send & last),
            .up_i      (send & ~last),
            .count_o   (count_r)
        );
        assign ser.ser_data = words[count_r];
    end else begin : g_single
        // A one-word packet is pure wiring; the clock and reset have nothing to drive.
        logic unused_single;
        assign count_r       = '0;
        assign ser.ser_data  = words[0];
        assign unused_single = clk_i ^ reset_n_i ^ send;
    end

    assign ser.ser_v         = par.par_v;
    assign ser.ser_last      = last;
    assign par.par_ready_and = last & ser.ser_ready_and;

    // Upstream must hold the packet and its length until it has been consumed.
    a_par_stable: assert property (
        @(posedge clk_i) disable iff (!reset_n_i)
        (par.par_v && !par.par_ready_and) |=>
            (!par.par_v || ($stable(par.par_data) && $stable(par.par_len))))
        else $error("bsg_piso: parallel packet changed before it was consumed");

    if (use_len_p != 0) begin : g_len_checks
        a_len_range: assert property (
            @(posedge clk_i) disable iff (!reset_n_i)
            par.par_v |-> (par.par_len <= max_idx_lp))
            else $warning("bsg_piso: len_i above els_p-1, clamped");

        a_len_shrink: assert property (
            @(posedge clk_i) disable iff (!reset_n_i)
            par.par_v |-> (count_r <= len_eff))
            else $error("bsg_piso: len_i dropped below the words already sent");
    end

endmodule

// File: tb/tb_bsg_parallel_in_serial_out_passthrough.sv
// Directed bench for the parallel-in/serial-out passthrough: four configurations
// driven from a vector table, plus stall, back-to-back and mid-packet reset sequences.
module tb_bsg_parallel_in_serial_out_passthrough;
    import bsg_parallel_in_serial_out_passthrough_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    bsg_parallel_in_serial_out_passthrough_if #(.width_p(8), .els_p(4)) if0 ();
    bsg_parallel_in_serial_out_passthrough_if #(.width_p(8), .els_p(4)) if1 ();
    bsg_parallel_in_serial_out_passthrough_if #(.width_p(8), .els_p(4)) if2 ();
    bsg_parallel_in_serial_out_passthrough_if #(.width_p(8), .els_p(1)) if3 ();

    bsg_parallel_in_serial_out_passthrough #(.width_p(8), .els_p(4), .hi_to_lo_p(0), .use_len_p(0))
        dut0 (.clk_i(clk), .reset_n_i(rst_n), .par(if0), .ser(if0));
    bsg_parallel_in_serial_out_passthrough #(.width_p(8), .els_p(4), .hi_to_lo_p(1), .use_len_p(0))
        dut1 (.clk_i(clk), .reset_n_i(rst_n), .par(if1), .ser(if1));
    bsg_parallel_in_serial_out_passthrough #(.width_p(8), .els_p(4), .hi_to_lo_p(0), .use_len_p(1))
        dut2 (.clk_i(clk), .reset_n_i(rst_n), .par(if2), .ser(if2));
    bsg_parallel_in_serial_out_passthrough #(.width_p(8), .els_p(1), .hi_to_lo_p(0), .use_len_p(0))
        dut3 (.clk_i(clk), .reset_n_i(rst_n), .par(if3), .ser(if3));

    typedef struct {
        int          id;
        logic        v;
        logic        r;
        logic [31:0] d;
        logic [1:0]  len;
        logic        ev;
        logic [7:0]  ed;
        logic        el;
        logic        er;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(int id, logic v, logic r, logic [31:0] d, logic [1:0] len,
                                logic ev, logic [7:0] ed, logic el, logic er);
        vec_t x;
        x.id = id; x.v = v; x.r = r; x.d = d; x.len = len;
        x.ev = ev; x.ed = ed; x.el = el; x.er = er;
        return x;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(int id, logic v, logic r, logic [31:0] d, logic [1:0] len);
        case (id)
            0: begin if0.par_v = v; if0.ser_ready_and = r; if0.par_data = d; if0.par_len = len; end
            1: begin if1.par_v = v; if1.ser_ready_and = r; if1.par_data = d; if1.par_len = len; end
            2: begin if2.par_v = v; if2.ser_ready_and = r; if2.par_data = d; if2.par_len = len; end
            default: begin
                if3.par_v = v; if3.ser_ready_and = r; if3.par_data = d[7:0]; if3.par_len = len[0];
            end
        endcase
    endtask

    task automatic sample(int id, output logic v, output logic [7:0] d, output logic l, output logic rdy);
        case (id)
            0: begin v = if0.ser_v; d = if0.ser_data; l = if0.ser_last; rdy = if0.par_ready_and; end
            1: begin v = if1.ser_v; d = if1.ser_data; l = if1.ser_last; rdy = if1.par_ready_and; end
            2: begin v = if2.ser_v; d = if2.ser_data; l = if2.ser_last; rdy = if2.par_ready_and; end
            default: begin v = if3.ser_v; d = if3.ser_data; l = if3.ser_last; rdy = if3.par_ready_and; end
        endcase
    endtask

    task automatic check_out(int id, string tag, logic ev, logic [7:0] ed, logic el, logic er);
        logic       ov, ol, orr;
        logic [7:0] od;
        sample(id, ov, od, ol, orr);
        check({tag, "_v"},    ov,  ev);
        check({tag, "_data"}, od,  ed);
        check({tag, "_last"}, ol,  el);
        check({tag, "_rdy"},  orr, er);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] pkt;
        logic        r;
        int          idx, words, npk, cyc;

        for (int i = 0; i < 4; i++) drive(i, 1'b0, 1'b0, 32'h0, 2'd0);

        // Reset: index is 0 and outputs already reflect word 0.
        rst_n = 1'b0;
        drive(0, 1'b1, 1'b1, 32'h44332211, 2'd0);
        #1;
        check_out(0, "reset", 1'b1, 8'h11, 1'b0, 1'b0);
        @(posedge clk); @(posedge clk); #1;
        check_out(0, "reset_hold", 1'b1, 8'h11, 1'b0, 1'b0);
        @(negedge clk);
        drive(0, 1'b0, 1'b1, 32'h44332211, 2'd0);
        rst_n = 1'b1;

        // els_p=4, lo-to-hi: full packet, back-to-back packet with stalls, then idle.
        vecs.push_back(mk(0, 1, 1, 32'h44332211, 0, 1, 8'h11, 0, 0));
        vecs.push_back(mk(0, 1, 1, 32'h44332211, 0, 1, 8'h22, 0, 0));
        vecs.push_back(mk(0, 1, 1, 32'h44332211, 0, 1, 8'h33, 0, 0));
        vecs.push_back(mk(0, 1, 1, 32'h44332211, 0, 1, 8'h44, 1, 1));
        vecs.push_back(mk(0, 1, 1, 32'h88776655, 0, 1, 8'h55, 0, 0));
        vecs.push_back(mk(0, 1, 0, 32'h88776655, 0, 1, 8'h66, 0, 0));
        vecs.push_back(mk(0, 1, 1, 32'h88776655, 0, 1, 8'h66, 0, 0));
        vecs.push_back(mk(0, 1, 1, 32'h88776655, 0, 1, 8'h77, 0, 0));
        vecs.push_back(mk(0, 1, 0, 32'h88776655, 0, 1, 8'h88, 1, 0));
        vecs.push_back(mk(0, 1, 1, 32'h88776655, 0, 1, 8'h88, 1, 1));
        vecs.push_back(mk(0, 0, 1, 32'h88776655, 0, 0, 8'h55, 0, 0));
        // hi-to-lo ordering.
        vecs.push_back(mk(1, 1, 1, 32'h44332211, 0, 1, 8'h44, 0, 0));
        vecs.push_back(mk(1, 1, 1, 32'h44332211, 0, 1, 8'h33, 0, 0));
        vecs.push_back(mk(1, 1, 1, 32'h44332211, 0, 1, 8'h22, 0, 0));
        vecs.push_back(mk(1, 1, 1, 32'h44332211, 0, 1, 8'h11, 1, 1));
        vecs.push_back(mk(1, 0, 1, 32'h44332211, 0, 0, 8'h44, 0, 0));
        // Per-packet length: 2 words, then 3 words, then a 1-word packet.
        vecs.push_back(mk(2, 1, 1, 32'hDDCCBBAA, 1, 1, 8'hAA, 0, 0));
        vecs.push_back(mk(2, 1, 1, 32'hDDCCBBAA, 1, 1, 8'hBB, 1, 1));
        vecs.push_back(mk(2, 1, 1, 32'h11223344, 2, 1, 8'h44, 0, 0));
        vecs.push_back(mk(2, 1, 1, 32'h11223344, 2, 1, 8'h33, 0, 0));
        vecs.push_back(mk(2, 1, 1, 32'h11223344, 2, 1, 8'h22, 1, 1));
        vecs.push_back(mk(2, 1, 1, 32'h000000EE, 0, 1, 8'hEE, 1, 1));
        vecs.push_back(mk(2, 1, 0, 32'h000000EE, 0, 1, 8'hEE, 1, 0));
        vecs.push_back(mk(2, 0, 1, 32'h000000EE, 0, 0, 8'hEE, 1, 1));
        // els_p=1: pure wiring, ready_and_o follows ready_and_i.
        vecs.push_back(mk(3, 1, 1, 32'h0000005A, 0, 1, 8'h5A, 1, 1));
        vecs.push_back(mk(3, 1, 0, 32'h0000005A, 0, 1, 8'h5A, 1, 0));
        vecs.push_back(mk(3, 0, 1, 32'h000000A5, 0, 0, 8'hA5, 1, 1));

        foreach (vecs[k]) begin
            @(negedge clk);
            drive(vecs[k].id, vecs[k].v, vecs[k].r, vecs[k].d, vecs[k].len);
            #1;
            check_out(vecs[k].id, $sformatf("vec%0d", k),
                      vecs[k].ev, vecs[k].ed, vecs[k].el, vecs[k].er);
        end

        // Random 20% stalls over 100 packets; the model tracks the expected word index.
        idx = 0; words = 0; npk = 0; cyc = 0;
        pkt = $urandom;
        while (npk < 100 && cyc < 5000) begin
            @(negedge clk);
            r = ($urandom_range(0, 4) != 0);
            drive(0, 1'b1, r, pkt, 2'd0);
            #1;
            check_out(0, $sformatf("rand_c%0d", cyc), 1'b1, pkt[idx*8 +: 8],
                      (idx == 3), (idx == 3) && r);
            if (r) begin
                words++;
                if (idx == 3) begin
                    idx = 0;
                    npk++;
                    pkt = $urandom;
                end else begin
                    idx++;
                end
            end
            cyc++;
        end
        check("rand_packets", npk, 100);
        check("rand_words", words, 400);
        @(negedge clk);
        drive(0, 1'b0, 1'b1, pkt, 2'd0);

        // Asynchronous reset after two beats: the packet replays from word 0.
        @(negedge clk); drive(0, 1'b1, 1'b1, 32'h44332211, 2'd0); #1;
        check_out(0, "rst_b0", 1'b1, 8'h11, 1'b0, 1'b0);
        @(negedge clk); #1;
        check_out(0, "rst_b1", 1'b1, 8'h22, 1'b0, 1'b0);
        @(negedge clk); #1;
        check_out(0, "rst_b2", 1'b1, 8'h33, 1'b0, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        check_out(0, "rst_async", 1'b1, 8'h11, 1'b0, 1'b0);
        @(negedge clk); rst_n = 1'b1; #1;
        check_out(0, "replay0", 1'b1, 8'h11, 1'b0, 1'b0);
        @(negedge clk); #1;
        check_out(0, "replay1", 1'b1, 8'h22, 1'b0, 1'b0);
        @(negedge clk); #1;
        check_out(0, "replay2", 1'b1, 8'h33, 1'b0, 1'b0);
        @(negedge clk); #1;
        check_out(0, "replay3", 1'b1, 8'h44, 1'b1, 1'b1);
        @(negedge clk); drive(0, 1'b0, 1'b1, 32'h44332211, 2'd0); #1;
        check_out(0, "replay_done", 1'b0, 8'h11, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
